// File: rtl/echo_meter.sv
// ---------------------------------------------------------------------------
// echo_meter
//
// Times the ultrasonic sensor's echo pulse after the trigger controller has
// fired. The width is counted on the 1 MHz clock and converted to whole
// centimetres by counting CM_DIV-cycle chunks. A result is held on the outputs
// and announced with a one-cycle valid strobe.
//
// Ports:
//   clk       in   1 MHz clock
//   clr       in   asynchronous active-low reset
//   start     in   one-cycle pulse when the trigger pulse ends
//   echo      in   raw asynchronous echo line from the sensor
//   busy      out  high while a measurement is in progress
//   valid     out  one-cycle strobe, a new result is on the outputs
//   dist_cm   out  last measured distance in cm (held)
//   timeout   out  last result saw no echo rise within ARM_TIMEOUT cycles
//   range_err out  last result saturated at MAX_CM
//   dist_bcd  out  (ECHO_BCD_EN only) three BCD digits of dist_cm
//
// Build option: define ECHO_BCD_EN to add the dist_bcd output. The result is
// then converted by a 9-cycle sequential double-dabble before valid fires.
// ---------------------------------------------------------------------------
module echo_meter #(
    parameter int CM_DIV      = 58,
    parameter int MAX_CM      = 400,
    parameter int ARM_TIMEOUT = 30000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        echo,
    output logic        busy,
    output logic        valid,
    output logic [8:0]  dist_cm,
    output logic        timeout,
    output logic        range_err
`ifdef ECHO_BCD_EN
    ,
    output logic [11:0] dist_bcd
`endif
);

    localparam logic [5:0]  SUB_LAST  = 6'(CM_DIV - 1);
    localparam logic [8:0]  CM_LIMIT  = 9'(MAX_CM);
    localparam logic [15:0] WAIT_LAST = 16'(ARM_TIMEOUT - 1);

`ifdef ECHO_BCD_EN
    typedef enum logic [2:0] {IDLE, WAIT_RISE, MEASURE, CONVERT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, DONE} state_t;
`endif

    state_t      state;
    logic [15:0] wait_cnt;
    logic [5:0]  sub;
    logic [8:0]  cm;
    logic [8:0]  cm_inc;

    logic        echo_s1;
    logic        echo_s2;
    logic        echo_s3;
    logic        rise;
    logic        fall;

    // A measurement finishes this cycle; the values to be reported.
    logic        fin;
    logic [8:0]  fin_dist;
    logic        fin_to;
    logic        fin_re;

`ifdef ECHO_BCD_EN
    logic [8:0]  conv_bin;
    logic [11:0] conv_bcd;
    logic [3:0]  conv_cnt;
    logic [8:0]  hold_cm;
    logic        hold_to;
    logic        hold_re;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_next;
`endif

    // Two-flop synchronizer plus a third flop used only for edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_s3 <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_s3 <= echo_s2;
        end
    end

    assign rise   = echo_s2 & ~echo_s3;
    assign fall   = ~echo_s2 & echo_s3;
    assign cm_inc = cm + 9'd1;

    // Decide whether the current cycle ends the measurement and with which
    // result. A fall wins over a same-cycle centimetre wrap, so the reported
    // distance is the value before that wrap.
    always_comb begin
        fin      = 1'b0;
        fin_dist = 9'd0;
        fin_to   = 1'b0;
        fin_re   = 1'b0;
        case (state)
            WAIT_RISE: begin
                if (!rise && (wait_cnt == WAIT_LAST)) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    fin      = 1'b1;
                    fin_dist = cm;
                end else if ((sub == SUB_LAST) && (cm_inc == CM_LIMIT)) begin
                    fin      = 1'b1;
                    fin_dist = CM_LIMIT;
                    fin_re   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef ECHO_BCD_EN
    // One double-dabble step: add 3 to any digit of 5 or more, then shift the
    // next binary bit (MSB first) into the BCD register.
    always_comb begin
        bcd_adj = conv_bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_next = {bcd_adj[10:0], conv_bin[8]};
`endif

    // Main controller. All result fields change only on entry to DONE, so the
    // display logic always sees a consistent set alongside valid.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            sub       <= 6'd0;
            cm        <= 9'd0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            dist_cm   <= 9'd0;
            timeout   <= 1'b0;
            range_err <= 1'b0;
`ifdef ECHO_BCD_EN
            conv_bin  <= 9'd0;
            conv_bcd  <= 12'd0;
            conv_cnt  <= 4'd0;
            hold_cm   <= 9'd0;
            hold_to   <= 1'b0;
            hold_re   <= 1'b0;
            dist_bcd  <= 12'h000;
`endif
        end else begin
            valid <= 1'b0;
            if (fin) begin
`ifdef ECHO_BCD_EN
                state    <= CONVERT;
                hold_cm  <= fin_dist;
                hold_to  <= fin_to;
                hold_re  <= fin_re;
                conv_bin <= fin_dist;
                conv_bcd <= 12'd0;
                conv_cnt <= 4'd0;
`else
                state     <= DONE;
                valid     <= 1'b1;
                busy      <= 1'b0;
                dist_cm   <= fin_dist;
                timeout   <= fin_to;
                range_err <= fin_re;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= WAIT_RISE;
                            wait_cnt <= 16'd0;
                            busy     <= 1'b1;
                        end
                    end
                    WAIT_RISE: begin
                        // The rise cycle itself is the first counted cycle.
                        if (rise) begin
                            state <= MEASURE;
                            sub   <= 6'd1;
                            cm    <= 9'd0;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    MEASURE: begin
                        if (sub == SUB_LAST) begin
                            sub <= 6'd0;
                            cm  <= cm_inc;
                        end else begin
                            sub <= sub + 6'd1;
                        end
                    end
`ifdef ECHO_BCD_EN
                    CONVERT: begin
                        conv_bcd <= bcd_next;
                        conv_bin <= {conv_bin[7:0], 1'b0};
                        conv_cnt <= conv_cnt + 4'd1;
                        if (conv_cnt == 4'd8) begin
                            state     <= DONE;
                            valid     <= 1'b1;
                            busy      <= 1'b0;
                            dist_cm   <= hold_cm;
                            dist_bcd  <= bcd_next;
                            timeout   <= hold_to;
                            range_err <= hold_re;
                        end
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
